// File: rtl/mandelbrot_iter_ctrl.sv
// mandelbrot_iter_ctrl: per-pixel iteration sequencer driving an external z^2+c ALU
// Ports: clk, rst_n (async active-low); start, in_cr, in_ci, max_iter request a pixel;
// busy, done, iter_count, escaped report it; alu_start and alu_cr/ci/zr/zi feed the ALU;
// alu_finished, alu_out_zr/zi, alu_size, alu_overflow return each step's result.
module mandelbrot_iter_ctrl #(
  parameter int WIDTH  = 8,
  parameter int ITER_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic signed [WIDTH-1:0]  in_cr,
  input  logic signed [WIDTH-1:0]  in_ci,
  input  logic        [ITER_W-1:0] max_iter,
  output logic                     busy,
  output logic                     done,
  output logic        [ITER_W-1:0] iter_count,
  output logic                     escaped,
  output logic                     alu_start,
  output logic signed [WIDTH-1:0]  alu_cr,
  output logic signed [WIDTH-1:0]  alu_ci,
  output logic signed [WIDTH-1:0]  alu_zr,
  output logic signed [WIDTH-1:0]  alu_zi,
  input  logic                     alu_finished,
  input  logic signed [WIDTH-1:0]  alu_out_zr,
  input  logic signed [WIDTH-1:0]  alu_out_zi,
  input  logic                     alu_size,
  input  logic                     alu_overflow
);
  typedef enum logic [1:0] {IDLE, KICK, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic signed [WIDTH-1:0] cr_q, cr_d, ci_q, ci_d, zr_q, zr_d, zi_q, zi_d;
  logic [ITER_W-1:0] max_q, max_d, cnt_q, cnt_d;
  logic esc_q, esc_d, busy_q, done_q, kick_q;
  always_comb begin
    state_d = state_q;
    cr_d    = cr_q;
    ci_d    = ci_q;
    zr_d    = zr_q;
    zi_d    = zi_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    esc_d   = esc_q;
    case (state_q)
      IDLE: if (start) begin
        cr_d    = in_cr;
        ci_d    = in_ci;
        max_d   = max_iter;
        zr_d    = '0;
        zi_d    = '0;
        cnt_d   = '0;
        esc_d   = 1'b0;
        state_d = (max_iter == '0) ? DONE : KICK;
      end
      KICK: state_d = WAIT;
      WAIT: if (alu_finished) begin
        zr_d    = alu_out_zr;
        zi_d    = alu_out_zi;
        cnt_d   = cnt_q + 1'b1;
        esc_d   = alu_size | alu_overflow;
        state_d = (esc_d || cnt_d == max_q) ? DONE : KICK;
      end
      default: state_d = IDLE;
    endcase
  end
  // Status strobes are registered from the next state so they line up exactly with the state they flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cr_q    <= '0;
      ci_q    <= '0;
      zr_q    <= '0;
      zi_q    <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
      esc_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      kick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cr_q    <= cr_d;
      ci_q    <= ci_d;
      zr_q    <= zr_d;
      zi_q    <= zi_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      esc_q   <= esc_d;
      busy_q  <= (state_d == KICK) || (state_d == WAIT);
      done_q  <= state_d == DONE;
      kick_q  <= state_d == KICK;
    end
  end
  assign busy       = busy_q;
  assign done       = done_q;
  assign alu_start  = kick_q;
  assign iter_count = cnt_q;
  assign escaped    = esc_q;
  assign alu_cr     = cr_q;
  assign alu_ci     = ci_q;
  assign alu_zr     = zr_q;
  assign alu_zi     = zi_q;
endmodule

// File: tb/tb_mandelbrot_iter_ctrl.sv
// tb_mandelbrot_iter_ctrl: directed self-checking bench with a latency-3 model ALU
module tb_mandelbrot_iter_ctrl;
  logic clk = 0, rst_n = 1, start = 0, stray = 0;
  logic signed [7:0] in_cr = 0, in_ci = 0;
  logic [7:0] max_iter = 0;
  logic busy, done, escaped, alu_start, alu_finished, alu_size, alu_overflow;
  logic [7:0] iter_count;
  logic signed [7:0] alu_cr, alu_ci, alu_zr, alu_zi, alu_out_zr, alu_out_zi;
  logic [2:0] pipe = 0;
  int n_kick = 0, n_done = 0, cyc = 0, base = 0, size_step = 0, ovf_step = 0;
  int checks = 0, failures = 0;
  int a, d, nd0;

  mandelbrot_iter_ctrl #(.WIDTH(8), .ITER_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_cr(in_cr), .in_ci(in_ci), .max_iter(max_iter),
    .busy(busy), .done(done), .iter_count(iter_count), .escaped(escaped), .alu_start(alu_start),
    .alu_cr(alu_cr), .alu_ci(alu_ci), .alu_zr(alu_zr), .alu_zi(alu_zi), .alu_finished(alu_finished),
    .alu_out_zr(alu_out_zr), .alu_out_zi(alu_out_zi), .alu_size(alu_size), .alu_overflow(alu_overflow)
  );

  always #5 clk = ~clk;

  // Model ALU: result valid 3 cycles after the alu_start cycle; step k returns z = (3k, -k).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    pipe <= {pipe[1:0], alu_start};
    if (alu_start) n_kick <= n_kick + 1;
    if (done) n_done <= n_done + 1;
  end
  assign alu_finished = pipe[2] | stray;
  assign alu_out_zr   = 8'((n_kick - base) * 3);
  assign alu_out_zi   = 8'(base - n_kick);
  assign alu_size     = pipe[2] && (n_kick - base) == size_step;
  assign alu_overflow = pipe[2] && (n_kick - base) == ovf_step;

  task automatic start_pixel(input logic signed [7:0] cr, input logic signed [7:0] ci,
                             input logic [7:0] mi, output int acc);
    @(negedge clk);
    base = n_kick; start = 1; in_cr = cr; in_ci = ci; max_iter = mi;
    @(negedge clk);
    start = 0; acc = cyc;
  endtask

  task automatic wait_done(output int de);
    de = -1000;
    for (int i = 0; i < 300; i++) begin
      if (done) begin de = cyc; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 0;
    #1;
    checks++; if ({busy, done, alu_start, escaped} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, alu_start, escaped}); end
    checks++; if ({iter_count, alu_cr, alu_ci, alu_zr, alu_zi} !== 40'd0) begin failures++; $display("FAIL reset_regs got=%h exp=0", {iter_count, alu_cr, alu_ci, alu_zr, alu_zi}); end
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_no_escape;
    size_step = 0; ovf_step = 0;
    start_pixel(8'sd20, -8'sd10, 8'd4, a);
    checks++; if ({busy, alu_start} !== 2'b11) begin failures++; $display("FAIL kick_flags got=%b exp=11", {busy, alu_start}); end
    in_cr = 8'sd99; in_ci = 0; max_iter = 1;
    wait_done(d);
    checks++; if (d - a + 1 !== 17) begin failures++; $display("FAIL lat_n4 got=%0d exp=17", d - a + 1); end
    checks++; if (n_kick - base !== 4) begin failures++; $display("FAIL kicks_n4 got=%0d exp=4", n_kick - base); end
    checks++; if ({iter_count, escaped, busy} !== {8'd4, 2'b00}) begin failures++; $display("FAIL res_n4 got=%0d/%b/%b exp=4/0/0", iter_count, escaped, busy); end
    checks++; if ({alu_cr, alu_ci} !== {8'sd20, -8'sd10}) begin failures++; $display("FAIL c_latched got=%0d,%0d exp=20,-10", alu_cr, alu_ci); end
    checks++; if ({alu_zr, alu_zi} !== {8'sd12, -8'sd4}) begin failures++; $display("FAIL z_final got=%0d,%0d exp=12,-4", alu_zr, alu_zi); end
    repeat (3) @(negedge clk);
    checks++; if ({done, iter_count, escaped} !== {1'b0, 8'd4, 1'b0}) begin failures++; $display("FAIL hold_n4 got=%b/%0d/%b exp=0/4/0", done, iter_count, escaped); end
  endtask

  task automatic test_size_escape;
    size_step = 2; ovf_step = 0;
    start_pixel(8'sd5, 8'sd6, 8'd10, a);
    wait_done(d);
    checks++; if (d - a + 1 !== 9) begin failures++; $display("FAIL lat_size got=%0d exp=9", d - a + 1); end
    checks++; if ({iter_count, escaped} !== {8'd2, 1'b1}) begin failures++; $display("FAIL res_size got=%0d/%b exp=2/1", iter_count, escaped); end
    checks++; if ({alu_zr, alu_zi} !== {8'sd6, -8'sd2}) begin failures++; $display("FAIL z_size got=%0d,%0d exp=6,-2", alu_zr, alu_zi); end
    @(negedge clk);
  endtask

  task automatic test_ovf_limit;
    size_step = 0; ovf_step = 3;
    start_pixel(8'sd1, 8'sd2, 8'd3, a);
    wait_done(d);
    checks++; if (d - a + 1 !== 13) begin failures++; $display("FAIL lat_ovf got=%0d exp=13", d - a + 1); end
    checks++; if ({iter_count, escaped} !== {8'd3, 1'b1}) begin failures++; $display("FAIL res_ovf got=%0d/%b exp=3/1", iter_count, escaped); end
    @(negedge clk);
  endtask

  task automatic test_zero_iter;
    size_step = 0; ovf_step = 0;
    start_pixel(8'sd3, 8'sd3, 8'd0, a);
    wait_done(d);
    checks++; if (d - a + 1 !== 1) begin failures++; $display("FAIL lat_zero got=%0d exp=1", d - a + 1); end
    checks++; if ({iter_count, escaped, busy} !== {8'd0, 2'b00}) begin failures++; $display("FAIL res_zero got=%0d/%b/%b exp=0/0/0", iter_count, escaped, busy); end
    repeat (3) @(negedge clk);
    checks++; if (n_kick - base !== 0) begin failures++; $display("FAIL kicks_zero got=%0d exp=0", n_kick - base); end
  endtask

  task automatic test_ignore;
    size_step = 0; ovf_step = 0;
    nd0 = n_done;
    start_pixel(8'sd5, 8'sd5, 8'd2, a);
    @(negedge clk);
    start = 1; max_iter = 0; in_cr = -8'sd1;
    @(negedge clk);
    start = 0;
    wait_done(d);
    checks++; if (d - a + 1 !== 9) begin failures++; $display("FAIL lat_ign got=%0d exp=9", d - a + 1); end
    start = 1; max_iter = 3;
    @(negedge clk);
    start = 0; stray = 1;
    @(negedge clk);
    stray = 0;
    repeat (3) @(negedge clk);
    checks++; if ({busy, done, alu_start} !== 3'b000) begin failures++; $display("FAIL ign_idle got=%b exp=000", {busy, done, alu_start}); end
    checks++; if (n_kick - base !== 2 || n_done - nd0 !== 1) begin failures++; $display("FAIL ign_pulses got=kick%0d/done%0d exp=kick2/done1", n_kick - base, n_done - nd0); end
    checks++; if ({iter_count, escaped, alu_cr} !== {8'd2, 1'b0, 8'sd5}) begin failures++; $display("FAIL ign_res got=%0d/%b/%0d exp=2/0/5", iter_count, escaped, alu_cr); end
  endtask

  task automatic test_reset_mid;
    size_step = 0; ovf_step = 0;
    start_pixel(8'sd7, 8'sd3, 8'd5, a);
    repeat (2) @(negedge clk);
    nd0 = n_done;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", busy); end
    rst_n = 0;
    #1;
    checks++; if ({busy, done, alu_start, escaped, iter_count} !== 12'd0) begin failures++; $display("FAIL mid_rst_out got=%h exp=0", {busy, done, alu_start, escaped, iter_count}); end
    checks++; if ({alu_cr, alu_ci, alu_zr, alu_zi} !== 32'd0) begin failures++; $display("FAIL mid_rst_regs got=%h exp=0", {alu_cr, alu_ci, alu_zr, alu_zi}); end
    repeat (3) @(negedge clk);
    rst_n = 1;
    start_pixel(8'sd2, 8'sd4, 8'd1, a);
    wait_done(d);
    checks++; if (d - a + 1 !== 5) begin failures++; $display("FAIL lat_after_rst got=%0d exp=5", d - a + 1); end
    checks++; if ({iter_count, escaped} !== {8'd1, 1'b0}) begin failures++; $display("FAIL res_after_rst got=%0d/%b exp=1/0", iter_count, escaped); end
    @(negedge clk);
    checks++; if (n_done - nd0 !== 1) begin failures++; $display("FAIL done_after_rst got=%0d exp=1", n_done - nd0); end
  endtask

  initial begin
    test_reset;
    test_no_escape;
    test_size_escape;
    test_ovf_limit;
    test_zero_iter;
    test_ignore;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
